// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
// Carries ctrl/data/instr across one RV32I stage boundary with a valid/ready
// handshake. It supports synchronous flush, NOP bubble injection and a
// saturating starvation counter. in_ready comes straight from a flop, so a
// downstream stall never becomes a long combinational path upstream.
module pipeline_stage_skid #(
  parameter int unsigned               CTRL_W    = 3,
  parameter int unsigned               DATA_W    = 101,
  parameter int unsigned               INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]        NOP_INSTR = 32'h0000_0033,
  parameter int unsigned               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Main slot drives out_*; the skid slot catches the one entry accepted while main stalls.
  logic               main_v_q, main_v_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               skid_v_q, skid_v_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               in_ready_q, in_ready_d;
  logic [1:0]         occ_q, occ_d;
  logic [CNT_W-1:0]   bub_q, bub_d;
  logic               acc;
  logic               dlv;

  // Next-state: flush kills everything, otherwise refill main from skid first, then from input.
  always_comb begin
    acc          = in_valid & in_ready_q;
    dlv          = main_v_q & out_ready;
    main_v_d     = main_v_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    main_instr_d = main_instr_q;
    skid_v_d     = skid_v_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      main_v_d     = 1'b0;
      skid_v_d     = 1'b0;
      main_ctrl_d  = {CTRL_W{1'b0}};
      main_instr_d = NOP_INSTR;
    end else if (!main_v_q || dlv) begin
      if (skid_v_q) begin
        // in_ready is low while skid is full, so no new entry can arrive here.
        main_v_d     = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        main_instr_d = skid_instr_q;
        skid_v_d     = 1'b0;
      end else if (acc) begin
        main_v_d     = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
        main_instr_d = in_instr;
      end else begin
        // Nothing to present: inject a NOP bubble with cleared control.
        main_v_d     = 1'b0;
        main_ctrl_d  = {CTRL_W{1'b0}};
        main_instr_d = NOP_INSTR;
      end
    end else if (acc) begin
      skid_v_d     = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
      skid_instr_d = in_instr;
    end else begin
      main_v_d = main_v_q;
    end

    in_ready_d = ~skid_v_d;
    occ_d      = {1'b0, main_v_d} + {1'b0, skid_v_d};

    if (out_ready && !main_v_q && (bub_q != CNT_MAX)) begin
      bub_d = bub_q + CNT_ONE;
    end else begin
      bub_d = bub_q;
    end
  end

  // State register with synchronous reset to an empty, ready stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q     <= 1'b0;
      main_ctrl_q  <= {CTRL_W{1'b0}};
      main_data_q  <= {DATA_W{1'b0}};
      main_instr_q <= NOP_INSTR;
      skid_v_q     <= 1'b0;
      skid_ctrl_q  <= {CTRL_W{1'b0}};
      skid_data_q  <= {DATA_W{1'b0}};
      skid_instr_q <= NOP_INSTR;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
      bub_q        <= {CNT_W{1'b0}};
    end else begin
      main_v_q     <= main_v_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      main_instr_q <= main_instr_d;
      skid_v_q     <= skid_v_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
      bub_q        <= bub_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_v_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign out_instr  = main_instr_q;
  assign occupancy  = occ_q;
  assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Self-checking bench for pipeline_stage_skid: a queue model tracks accepted,
// not-yet-delivered entries and is compared against the stage every cycle.
// A second instance with CNT_W=2 exercises bubble counter saturation.
module tb_pipeline_stage_skid;

  localparam logic [31:0] NOP = 32'h0000_0033;

  typedef struct packed {
    logic [2:0]   c;
    logic [100:0] d;
    logic [31:0]  i;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [2:0]   in_ctrl;
  logic [100:0] in_data;
  logic [31:0]  in_instr;
  logic         in_ready, out_valid;
  logic [2:0]   out_ctrl;
  logic [100:0] out_data;
  logic [31:0]  out_instr;
  logic [1:0]   occupancy;
  logic [15:0]  bubble_cnt;
  logic         s_in_ready, s_out_valid;
  logic [2:0]   s_out_ctrl;
  logic [100:0] s_out_data;
  logic [31:0]  s_out_instr;
  logic [1:0]   s_occupancy;
  logic [1:0]   s_bubble_cnt;

  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b0;
  ent_t q[$];
  logic [15:0] exp_bub  = 16'd0;
  logic [1:0]  exp_bub2 = 2'd0;

  pipeline_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_instr(out_instr),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipeline_stage_skid #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_instr(s_out_instr),
    .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] c, input logic [100:0] d, input logic [31:0] i);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_instr = i;
  endtask

  // One clock cycle: compare outputs to the model, advance the model, step the clock.
  task automatic tick();
    int          sz;
    logic        acc, dlv, ev, er;
    logic [1:0]  eo;
    logic [2:0]  ec;
    logic [31:0] ei;
    ent_t        e;
    sz  = q.size();
    ev  = (sz > 0);
    er  = (sz < 2);
    eo  = 2'(sz);
    ec  = ev ? q[0].c : 3'd0;
    ei  = ev ? q[0].i : NOP;
    acc = in_valid && er;
    dlv = out_ready && ev;
    if (sb_en) begin
      checks++;
      if (occupancy !== eo) begin errors++; $display("FAIL occupancy got=%0d exp=%0d t=%0t", occupancy, eo, $time); end
      checks++;
      if (in_ready !== er) begin errors++; $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, er, $time); end
      checks++;
      if (out_valid !== ev) begin errors++; $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, ev, $time); end
      checks++;
      if (out_ctrl !== ec || out_instr !== ei) begin
        errors++; $display("FAIL head ctrl/instr got=%h/%h exp=%h/%h t=%0t", out_ctrl, out_instr, ec, ei, $time);
      end
      if (ev) begin
        checks++;
        if (out_data !== q[0].d) begin errors++; $display("FAIL head data got=%h exp=%h t=%0t", out_data, q[0].d, $time); end
      end
      checks++;
      if (bubble_cnt !== exp_bub) begin errors++; $display("FAIL bubble_cnt got=%0d exp=%0d t=%0t", bubble_cnt, exp_bub, $time); end
      checks++;
      if ({s_out_valid, s_in_ready, s_occupancy, s_out_ctrl, s_out_instr, s_bubble_cnt} !== {ev, er, eo, ec, ei, exp_bub2} ||
          (ev && s_out_data !== q[0].d)) begin
        errors++; $display("FAIL sat_instance v/rdy/occ/instr/bub got=%b/%b/%0d/%h/%0d exp=%b/%b/%0d/%h/%0d t=%0t",
                           s_out_valid, s_in_ready, s_occupancy, s_out_instr, s_bubble_cnt, ev, er, eo, ei, exp_bub2, $time);
      end
    end
    if (rst) begin
      exp_bub  = 16'd0;
      exp_bub2 = 2'd0;
    end else if (out_ready && !ev) begin
      if (exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
      if (exp_bub2 != 2'd3) exp_bub2 = exp_bub2 + 2'd1;
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      if (dlv) void'(q.pop_front());
      if (acc) begin
        e.c = in_ctrl; e.d = in_data; e.i = in_instr;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 101'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_ctrl, out_instr, in_ready, occupancy, bubble_cnt, s_bubble_cnt} !==
        {1'b0, 3'd0, NOP, 1'b1, 2'd0, 16'd0, 2'd0}) begin
      errors++; $display("FAIL reset v/ctrl/instr/rdy/occ/bub got=%b/%h/%h/%b/%0d/%0d", out_valid, out_ctrl, out_instr, in_ready, occupancy, bubble_cnt);
    end
    sb_en = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] ins;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ins = 32'h00A0_0093 + 32'(k) * 32'h0010_0000;
      drive(1'b1, 3'(k), {69'd0, 32'(k * 7)}, ins);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== ins || in_ready !== 1'b1 || occupancy > 2'd1) begin
        errors++; $display("FAIL stream[%0d] instr got=%h exp=%h rdy=%b occ=%0d", k, out_instr, ins, in_ready, occupancy);
      end
    end
    drive(1'b0, 3'd0, 101'd0, 32'd0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 101'hA, 32'h0000_0A13); tick();
    drive(1'b1, 3'd2, 101'hB, 32'h0000_0B13); tick();
    drive(1'b1, 3'd3, 101'hC, 32'h0000_0C13); tick();
    checks++;
    if (out_instr !== 32'h0000_0A13 || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL backpressure_full instr got=%h exp=00000a13 occ=%0d rdy=%b", out_instr, occupancy, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_instr !== 32'h0000_0B13 || out_valid !== 1'b1) begin
      errors++; $display("FAIL backpressure_B got=%h exp=00000b13", out_instr);
    end
    tick();
    drive(1'b0, 3'd0, 101'd0, 32'd0);
    checks++;
    if (out_instr !== 32'h0000_0C13 || out_valid !== 1'b1) begin
      errors++; $display("FAIL backpressure_C got=%h exp=00000c13", out_instr);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 3'd5, 101'h1, 32'h0000_1113); tick();
    drive(1'b1, 3'd6, 101'h2, 32'h0000_2213); tick();
    drive(1'b1, 3'd7, 101'h3, 32'h0000_3313);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_ctrl, occupancy, in_ready} !== {1'b0, NOP, 3'd0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL flush_full v/instr/ctrl/occ/rdy got=%b/%h/%h/%0d/%b", out_valid, out_instr, out_ctrl, occupancy, in_ready);
    end
    drive(1'b1, 3'd4, 101'h4, 32'h0000_4413); tick();
    drive(1'b1, 3'd5, 101'h5, 32'h0000_5513);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 101'd0, 32'd0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL flush_drop got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 3'd0, 101'd0, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (s_bubble_cnt !== exp_seq[k]) begin
        errors++; $display("FAIL starvation[%0d] bubble_cnt got=%0d exp=%0d", k, s_bubble_cnt, exp_seq[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] r;
    for (int k = 0; k < 10000; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) drive(1'b1, 3'($urandom), r[100:0], $urandom);
      else drive(1'b0, 3'bxxx, {101{1'bx}}, 32'hxxxx_xxxx);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 3'd0, 101'd0, 32'd0);
    out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_starvation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
